// File: rtl/decode_queue.sv
// decode_queue: buffered instruction decode front end.
// A DEPTH-entry FIFO of {instr, pc} feeds a registered decode output stage.
// Optional build macro DECODE_QUEUE_PERF_EN adds decoded/stall perf counters.
module decode_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       fetch_valid_i,
    output logic                       fetch_ready_o,
    input  logic [31:0]                fetch_instr_i,
    input  logic [XLEN-1:0]            fetch_pc_i,
    output logic                       dec_valid_o,
    input  logic                       dec_ready_i,
    output logic [31:0]                dec_instr_o,
    output logic [XLEN-1:0]            dec_pc_o,
    output logic [3:0]                 dec_class_o,
    output logic                       dec_reg_we_o,
    output logic                       dec_mem_we_o,
    output logic                       dec_mem_access_o,
    output logic                       dec_load_o,
    output logic                       dec_branch_o,
    output logic                       dec_jump_o,
    output logic                       dec_exc_o,
    output logic [3:0]                 dec_cause_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
`ifdef DECODE_QUEUE_PERF_EN
    ,
    output logic [63:0]                perf_decoded_o,
    output logic [63:0]                perf_stall_o
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            push;
    logic            pop;

    logic [31:0]     head_instr;
    logic [3:0]      d_class;
    logic            d_reg_we;
    logic            d_mem_we;
    logic            d_mem_access;
    logic            d_load;
    logic            d_branch;
    logic            d_jump;
    logic            d_exc;
    logic [3:0]      d_cause;

    assign push       = fetch_valid_i & fetch_ready_o;
    assign pop        = (count != '0) & (~dec_valid_o | dec_ready_i);
    assign count_next = count + CW'(push) - CW'(pop);
    assign head_instr = instr_mem[rd_ptr];
    assign occupancy_o = count;

    // FIFO storage write; contents need no reset since count gates use
    always_ff @(posedge clk_i) begin
        if (push && !flush_i && !rst_i) begin
            instr_mem[wr_ptr] <= fetch_instr_i;
            pc_mem[wr_ptr]    <= fetch_pc_i;
        end
    end

    // FIFO pointers, count and registered ready; flush beats push/pop
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            fetch_ready_o <= 1'b0;
        end else if (flush_i) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            fetch_ready_o <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count         <= count_next;
            fetch_ready_o <= (count_next != CW'(DEPTH));
        end
    end

    // Decode the FIFO head into class, control flags and exception cause
    always_comb begin
        d_class      = 4'd15;
        d_reg_we     = 1'b0;
        d_mem_we     = 1'b0;
        d_mem_access = 1'b0;
        d_load       = 1'b0;
        d_branch     = 1'b0;
        d_jump       = 1'b0;
        d_exc        = 1'b0;
        d_cause      = 4'd0;
        case (head_instr[6:0])
            7'b0110111: d_class = 4'd0;
            7'b0010111: d_class = 4'd1;
            7'b1101111: d_class = 4'd2;
            7'b1100111: d_class = 4'd3;
            7'b1100011: d_class = 4'd4;
            7'b0000011: d_class = 4'd5;
            7'b0100011: d_class = 4'd6;
            7'b0010011: d_class = 4'd7;
            7'b0110011: d_class = 4'd8;
            7'b0011011: d_class = 4'd9;
            7'b0111011: d_class = 4'd10;
            7'b1110011: d_class = 4'd11;
            7'b0001111: d_class = 4'd12;
            default:    d_class = 4'd15;
        endcase
        case (d_class)
            4'd0, 4'd1, 4'd7, 4'd8, 4'd9, 4'd10: d_reg_we = 1'b1;
            4'd2, 4'd3: begin
                d_reg_we = 1'b1;
                d_jump   = 1'b1;
            end
            4'd4: d_branch = 1'b1;
            4'd5: begin
                d_reg_we     = 1'b1;
                d_mem_access = 1'b1;
                d_load       = 1'b1;
            end
            4'd6: begin
                d_mem_we     = 1'b1;
                d_mem_access = 1'b1;
            end
            4'd11: begin
                if (head_instr == ECALL) begin
                    d_exc   = 1'b1;
                    d_cause = 4'd11;
                end else if (head_instr == EBREAK) begin
                    d_exc   = 1'b1;
                    d_cause = 4'd3;
                end else begin
                    d_reg_we = 1'b1;
                end
            end
            4'd15: begin
                d_exc   = 1'b1;
                d_cause = 4'd2;
            end
            default: d_reg_we = 1'b0;
        endcase
    end

    // Output stage: load on pop, clear on consume-with-empty, else hold
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dec_valid_o      <= 1'b0;
            dec_instr_o      <= '0;
            dec_pc_o         <= '0;
            dec_class_o      <= '0;
            dec_reg_we_o     <= 1'b0;
            dec_mem_we_o     <= 1'b0;
            dec_mem_access_o <= 1'b0;
            dec_load_o       <= 1'b0;
            dec_branch_o     <= 1'b0;
            dec_jump_o       <= 1'b0;
            dec_exc_o        <= 1'b0;
            dec_cause_o      <= '0;
        end else if (flush_i) begin
            dec_valid_o <= 1'b0;
        end else if (pop) begin
            dec_valid_o      <= 1'b1;
            dec_instr_o      <= head_instr;
            dec_pc_o         <= pc_mem[rd_ptr];
            dec_class_o      <= d_class;
            dec_reg_we_o     <= d_reg_we;
            dec_mem_we_o     <= d_mem_we;
            dec_mem_access_o <= d_mem_access;
            dec_load_o       <= d_load;
            dec_branch_o     <= d_branch;
            dec_jump_o       <= d_jump;
            dec_exc_o        <= d_exc;
            dec_cause_o      <= d_cause;
        end else if (dec_ready_i) begin
            dec_valid_o <= 1'b0;
        end
    end

`ifdef DECODE_QUEUE_PERF_EN
    // Perf counters: survive flush, clear only on reset, wrap naturally
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_decoded_o <= '0;
            perf_stall_o   <= '0;
        end else begin
            if (dec_valid_o && dec_ready_i)     perf_decoded_o <= perf_decoded_o + 64'd1;
            if (fetch_valid_i && !fetch_ready_o) perf_stall_o  <= perf_stall_o + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Directed testbench for decode_queue (DEPTH=4, XLEN=64).
// Build with DECODE_QUEUE_PERF_EN defined to also exercise the perf counters.
module tb_decode_queue;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_instr_i;
    logic [63:0] fetch_pc_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [31:0] dec_instr_o;
    logic [63:0] dec_pc_o;
    logic [3:0]  dec_class_o;
    logic        dec_reg_we_o;
    logic        dec_mem_we_o;
    logic        dec_mem_access_o;
    logic        dec_load_o;
    logic        dec_branch_o;
    logic        dec_jump_o;
    logic        dec_exc_o;
    logic [3:0]  dec_cause_o;
    logic [2:0]  occupancy_o;
`ifdef DECODE_QUEUE_PERF_EN
    logic [63:0] perf_decoded_o;
    logic [63:0] perf_stall_o;
`endif

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_pc [16];
    logic [31:0] ex_instr [13];
    logic [14:0] ex_exp [13];

    decode_queue #(.DEPTH(4), .XLEN(64)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .fetch_valid_i    (fetch_valid_i),
        .fetch_ready_o    (fetch_ready_o),
        .fetch_instr_i    (fetch_instr_i),
        .fetch_pc_i       (fetch_pc_i),
        .dec_valid_o      (dec_valid_o),
        .dec_ready_i      (dec_ready_i),
        .dec_instr_o      (dec_instr_o),
        .dec_pc_o         (dec_pc_o),
        .dec_class_o      (dec_class_o),
        .dec_reg_we_o     (dec_reg_we_o),
        .dec_mem_we_o     (dec_mem_we_o),
        .dec_mem_access_o (dec_mem_access_o),
        .dec_load_o       (dec_load_o),
        .dec_branch_o     (dec_branch_o),
        .dec_jump_o       (dec_jump_o),
        .dec_exc_o        (dec_exc_o),
        .dec_cause_o      (dec_cause_o),
        .occupancy_o      (occupancy_o)
`ifdef DECODE_QUEUE_PERF_EN
        ,
        .perf_decoded_o   (perf_decoded_o),
        .perf_stall_o     (perf_stall_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Offer one instruction and hold it until accepted, bounded
    task automatic push_item(input logic [63:0] pc, input logic [31:0] instr);
        logic acc;
        logic done;
        done = 1'b0;
        fetch_pc_i    = pc;
        fetch_instr_i = instr;
        fetch_valid_i = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            acc = fetch_ready_o;
            step();
            if (acc) done = 1'b1;
        end
        fetch_valid_i = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL push_timeout pc=%h got accepted=%b want 1", pc, done);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0; fetch_valid_i = 1'b0; dec_ready_i = 1'b0;
        fetch_instr_i = '0; fetch_pc_i = '0;
        step(); step(); step();
        checks++;
        if (dec_valid_o !== 1'b0) begin failures++; $display("FAIL reset_dec_valid got %b want 0", dec_valid_o); end
        checks++;
        if (fetch_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got %b want 0", fetch_ready_o); end
        checks++;
        if (occupancy_o !== 3'd0) begin failures++; $display("FAIL reset_occ got %0d want 0", occupancy_o); end
        checks++;
        if ({dec_pc_o, dec_instr_o, dec_class_o, dec_cause_o, dec_reg_we_o, dec_exc_o} !== '0) begin
            failures++; $display("FAIL reset_dec_fields got pc=%h instr=%h class=%0d want all 0", dec_pc_o, dec_instr_o, dec_class_o);
        end
        rst_i = 1'b0;
        step();
        checks++;
        if (fetch_ready_o !== 1'b1) begin failures++; $display("FAIL post_reset_ready got %b want 1", fetch_ready_o); end
    endtask

    task automatic test_single();
        dec_ready_i   = 1'b1;
        fetch_instr_i = 32'h0050_0093;
        fetch_pc_i    = 64'h1000;
        fetch_valid_i = 1'b1;
        step();
        fetch_valid_i = 1'b0;
        checks++;
        if (dec_valid_o !== 1'b0 || occupancy_o !== 3'd1) begin
            failures++; $display("FAIL single_cycle1 got valid=%b occ=%0d want valid=0 occ=1", dec_valid_o, occupancy_o);
        end
        step();
        checks++;
        if ({dec_valid_o, dec_class_o, dec_reg_we_o, dec_exc_o, dec_pc_o, dec_instr_o} !==
            {1'b1, 4'd7, 1'b1, 1'b0, 64'h1000, 32'h0050_0093}) begin
            failures++; $display("FAIL single_decode got valid=%b class=%0d we=%b exc=%b pc=%h want 1 7 1 0 1000",
                                 dec_valid_o, dec_class_o, dec_reg_we_o, dec_exc_o, dec_pc_o);
        end
        step();
        checks++;
        if (dec_valid_o !== 1'b0) begin failures++; $display("FAIL single_drain got %b want 0", dec_valid_o); end
    endtask

    task automatic test_backpressure();
        int k;
        int cyc;
        logic acc;
        dec_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) exp_pc[i] = 64'h2000 + 64'(4 * i);
        for (int i = 0; i < 5; i++) push_item(exp_pc[i], 32'h0000_0013 + 32'(i << 7));
        fetch_pc_i = exp_pc[5]; fetch_instr_i = 32'h0000_0293; fetch_valid_i = 1'b1;
        step(); step();
        checks++;
        if ({occupancy_o, fetch_ready_o, dec_valid_o} !== {3'd4, 1'b0, 1'b1}) begin
            failures++; $display("FAIL bp_full got occ=%0d ready=%b valid=%b want 4 0 1", occupancy_o, fetch_ready_o, dec_valid_o);
        end
        checks++;
        if (dec_pc_o !== exp_pc[0]) begin failures++; $display("FAIL bp_held_pc got %h want %h", dec_pc_o, exp_pc[0]); end
        dec_ready_i = 1'b1;
        k = 0; cyc = 0;
        for (int c = 0; c < 20 && k < 6; c++) begin
            if (dec_valid_o) begin
                checks++;
                if (dec_pc_o !== exp_pc[k]) begin failures++; $display("FAIL bp_order[%0d] got %h want %h", k, dec_pc_o, exp_pc[k]); end
                k++;
            end
            acc = fetch_valid_i & fetch_ready_o;
            step();
            cyc++;
            if (acc) fetch_valid_i = 1'b0;
        end
        checks++;
        if (cyc !== 6) begin failures++; $display("FAIL bp_throughput got %0d cycles want 6", cyc); end
        checks++;
        if (dec_valid_o !== 1'b0 || occupancy_o !== 3'd0) begin
            failures++; $display("FAIL bp_empty got valid=%b occ=%0d want 0 0", dec_valid_o, occupancy_o);
        end
    endtask

    task automatic test_simultaneous();
        dec_ready_i = 1'b0;
        for (int i = 0; i < 13; i++) exp_pc[i] = 64'h3000 + 64'(8 * i);
        for (int i = 0; i < 3; i++) push_item(exp_pc[i], 32'h0000_0033);
        checks++;
        if (occupancy_o !== 3'd2 || dec_valid_o !== 1'b1) begin
            failures++; $display("FAIL sim_setup got occ=%0d valid=%b want 2 1", occupancy_o, dec_valid_o);
        end
        dec_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (dec_valid_o !== 1'b1 || dec_pc_o !== exp_pc[i]) begin
                failures++; $display("FAIL sim_order[%0d] got valid=%b pc=%h want 1 %h", i, dec_valid_o, dec_pc_o, exp_pc[i]);
            end
            fetch_pc_i = exp_pc[3 + i]; fetch_instr_i = 32'h0000_0033; fetch_valid_i = 1'b1;
            step();
            checks++;
            if (occupancy_o !== 3'd2) begin failures++; $display("FAIL sim_occ[%0d] got %0d want 2", i, occupancy_o); end
        end
        fetch_valid_i = 1'b0;
        for (int i = 10; i < 13; i++) begin
            checks++;
            if (dec_valid_o !== 1'b1 || dec_pc_o !== exp_pc[i]) begin
                failures++; $display("FAIL sim_drain[%0d] got valid=%b pc=%h want 1 %h", i, dec_valid_o, dec_pc_o, exp_pc[i]);
            end
            step();
        end
        checks++;
        if (dec_valid_o !== 1'b0 || occupancy_o !== 3'd0) begin
            failures++; $display("FAIL sim_empty got valid=%b occ=%0d want 0 0", dec_valid_o, occupancy_o);
        end
    endtask

    task automatic test_flush();
        dec_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push_item(64'h4000 + 64'(4 * i), 32'h0000_0013);
        checks++;
        if (occupancy_o !== 3'd3 || dec_valid_o !== 1'b1 || fetch_ready_o !== 1'b1) begin
            failures++; $display("FAIL flush_setup got occ=%0d valid=%b ready=%b want 3 1 1", occupancy_o, dec_valid_o, fetch_ready_o);
        end
        flush_i = 1'b1;
        fetch_pc_i = 64'hDEAD; fetch_instr_i = 32'h0000_0013; fetch_valid_i = 1'b1;
        step();
        flush_i = 1'b0; fetch_valid_i = 1'b0;
        checks++;
        if ({dec_valid_o, occupancy_o, fetch_ready_o} !== {1'b0, 3'd0, 1'b1}) begin
            failures++; $display("FAIL flush_clear got valid=%b occ=%0d ready=%b want 0 0 1", dec_valid_o, occupancy_o, fetch_ready_o);
        end
        dec_ready_i = 1'b1;
        push_item(64'h5000, 32'h0000_0013);
        checks++;
        if (dec_valid_o !== 1'b0 || occupancy_o !== 3'd1) begin
            failures++; $display("FAIL flush_repush1 got valid=%b occ=%0d want 0 1", dec_valid_o, occupancy_o);
        end
        step();
        checks++;
        if (dec_valid_o !== 1'b1 || dec_pc_o !== 64'h5000) begin
            failures++; $display("FAIL flush_repush2 got valid=%b pc=%h want 1 5000", dec_valid_o, dec_pc_o);
        end
        step();
    endtask

    task automatic test_decode_exceptions();
        logic [14:0] got;
        // expected = {class, reg_we, mem_we, mem_access, load, branch, jump, exc, cause}
        ex_instr = '{32'h0000_0073, 32'h0010_0073, 32'hFFFF_FFFF, 32'h0000_4501, 32'h3000_1073,
                     32'h0000_00B7, 32'h0011_2023, 32'h0001_2083, 32'h0000_0463, 32'h0080_00EF,
                     32'h0000_80E7, 32'h0000_000F, 32'h0000_0017};
        ex_exp   = '{{4'd11, 7'b0000001, 4'd11}, {4'd11, 7'b0000001, 4'd3}, {4'd15, 7'b0000001, 4'd2},
                     {4'd15, 7'b0000001, 4'd2},  {4'd11, 7'b1000000, 4'd0}, {4'd0, 7'b1000000, 4'd0},
                     {4'd6, 7'b0110000, 4'd0},   {4'd5, 7'b1011000, 4'd0},  {4'd4, 7'b0000100, 4'd0},
                     {4'd2, 7'b1000010, 4'd0},   {4'd3, 7'b1000010, 4'd0},  {4'd12, 7'b0000000, 4'd0},
                     {4'd1, 7'b1000000, 4'd0}};
        dec_ready_i = 1'b1;
        for (int i = 0; i < 13; i++) begin
            fetch_instr_i = ex_instr[i]; fetch_pc_i = 64'h6000 + 64'(4 * i); fetch_valid_i = 1'b1;
            step();
            fetch_valid_i = 1'b0;
            step();
            got = {dec_class_o, dec_reg_we_o, dec_mem_we_o, dec_mem_access_o, dec_load_o,
                   dec_branch_o, dec_jump_o, dec_exc_o, dec_cause_o};
            checks++;
            if (dec_valid_o !== 1'b1 || dec_instr_o !== ex_instr[i] || got !== ex_exp[i]) begin
                failures++; $display("FAIL decode[%h] got valid=%b fields=%b want 1 %b", ex_instr[i], dec_valid_o, got, ex_exp[i]);
            end
            step();
        end
    endtask

`ifdef DECODE_QUEUE_PERF_EN
    task automatic test_perf();
        rst_i = 1'b1; step(); rst_i = 1'b0; step();
        dec_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) push_item(64'h7000 + 64'(4 * i), 32'h0000_0013);
        fetch_valid_i = 1'b1;
        step(); step(); step();
        fetch_valid_i = 1'b0;
        dec_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (perf_decoded_o !== 64'd5 || perf_stall_o !== 64'd3) begin
            failures++; $display("FAIL perf_counts got dec=%0d stall=%0d want 5 3", perf_decoded_o, perf_stall_o);
        end
        flush_i = 1'b1; step(); flush_i = 1'b0;
        checks++;
        if (perf_decoded_o !== 64'd5 || perf_stall_o !== 64'd3) begin
            failures++; $display("FAIL perf_flush got dec=%0d stall=%0d want 5 3", perf_decoded_o, perf_stall_o);
        end
        rst_i = 1'b1; step();
        checks++;
        if (perf_decoded_o !== 64'd0 || perf_stall_o !== 64'd0) begin
            failures++; $display("FAIL perf_reset got dec=%0d stall=%0d want 0 0", perf_decoded_o, perf_stall_o);
        end
        rst_i = 1'b0; step();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_decode_exceptions();
`ifdef DECODE_QUEUE_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
